// File: rtl/div_sched.sv
// Two-slot arbiter and start/stop sequencer for the shared iterative divider.
// Grants one DIV/DIVU at a time, captures HI/LO, and cancels on flush.
module div_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [1:0]  req_i,
  input  logic        signed0_i,
  input  logic        signed1_i,
  input  logic [31:0] op1_0_i,
  input  logic [31:0] op2_0_i,
  input  logic [31:0] op1_1_i,
  input  logic [31:0] op2_1_i,
  output logic [1:0]  stall_o,
  output logic        done_o,
  output logic        done_id_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        div_flush_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic          owner_q,   owner_d;
  logic          start_q,   start_d;
  logic          signed_q,  signed_d;
  logic [DW-1:0] op1_q,     op1_d;
  logic [DW-1:0] op2_q,     op2_d;
  logic [DW-1:0] hi_q,      hi_d;
  logic [DW-1:0] lo_q,      lo_d;
  logic          done_id_q, done_id_d;
  logic          grant_sel;

  // Fixed priority: the older slot 0 wins whenever it is requesting.
  assign grant_sel = ~req_i[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      start_q   <= 1'b0;
      signed_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      start_q   <= start_d;
      signed_q  <= signed_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_id_q <= done_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    start_d   = start_q;
    signed_d  = signed_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_id_d = done_id_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush_i && (req_i != 2'b00)) begin
          owner_d  = grant_sel;
          signed_d = grant_sel ? signed1_i : signed0_i;
          op1_d    = grant_sel ? op1_1_i : op1_0_i;
          op2_d    = grant_sel ? op2_1_i : op2_0_i;
          start_d  = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        start_d = 1'b1;
        // Flush leaves BUSY on the same edge the divider is flushed back to free.
        if (flush_i) begin
          start_d = 1'b0;
          state_d = ST_IDLE;
        end else if (div_ready_i) begin
          hi_d      = div_result_i[RW-1:DW];
          lo_d      = div_result_i[DW-1:0];
          done_id_d = owner_q;
          start_d   = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign done_o       = (state_q == ST_DONE) & ~flush_i;
  assign done_id_o    = done_id_q;
  assign stall_o      = req_i & ~{done_o & done_id_q, done_o & ~done_id_q};
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign div_start_o  = start_q;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign div_flush_o  = flush_i;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched with a cycle-accurate behavioural divider:
// 35 cycles after start for a nonzero divisor, 3 cycles for a zero divisor.
`timescale 1ns/1ps
module tb_div_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [1:0]  req_i;
  logic        signed0_i, signed1_i;
  logic [31:0] op1_0_i, op2_0_i, op1_1_i, op2_1_i;
  logic [1:0]  stall_o;
  logic        done_o, done_id_o;
  logic [31:0] hi_o, lo_o;
  logic        div_start_o, div_signed_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic        div_flush_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;

  typedef struct packed {
    logic        id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cyc;
    logic [1:0]  stall;
  } exp_t;

  exp_t sb[$];

  div_sched dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .req_i(req_i),
    .signed0_i(signed0_i), .signed1_i(signed1_i),
    .op1_0_i(op1_0_i), .op2_0_i(op2_0_i), .op1_1_i(op1_1_i), .op2_1_i(op2_1_i),
    .stall_o(stall_o), .done_o(done_o), .done_id_o(done_id_o),
    .hi_o(hi_o), .lo_o(lo_o),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_flush_o(div_flush_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: latches operands on start, result after fixed latency.
  logic        dv_busy;
  int          dv_cnt, dv_lat;
  logic [63:0] dv_res;

  function automatic logic [63:0] divide(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_busy <= 1'b0;
      dv_cnt  <= 0;
      dv_lat  <= 0;
      dv_res  <= 64'd0;
    end else if (div_flush_o) begin
      dv_busy <= 1'b0;
    end else if (dv_busy) begin
      if (dv_cnt == dv_lat) dv_busy <= 1'b0;
      else dv_cnt <= dv_cnt + 1;
    end else if (div_start_o) begin
      dv_busy <= 1'b1;
      dv_cnt  <= 1;
      dv_lat  <= (div_op2_o == 32'd0) ? 3 : 35;
      dv_res  <= divide(div_signed_o, div_op1_o, div_op2_o);
    end
  end

  assign div_ready_i  = dv_busy && (dv_cnt == dv_lat);
  assign div_result_i = div_ready_i ? dv_res : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] hi, input logic [31:0] lo,
                      input int at, input logic [1:0] stall);
    exp_t e;
    e.id = id; e.hi = hi; e.lo = lo; e.cyc = 32'(at); e.stall = stall;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_id", 64'(done_id_o), 64'(e.id));
        check("hi", 64'(hi_o), 64'(e.hi));
        check("lo", 64'(lo_o), 64'(e.lo));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("stall_at_done", 64'(stall_o), 64'(e.stall));
      end
    end
  end

  // Drops each slot's request after its own done, bounded by a cycle budget.
  task automatic run_until_clear(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (done_o) req_i[done_id_o] = 1'b0;
      if (req_i == 2'b00) break;
    end
    if (k >= budget) check("timeout_req_clear", 64'(req_i), 64'd0);
  endtask

  task automatic set_slot(input int s, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (s == 0) begin signed0_i = sgn; op1_0_i = a; op2_0_i = b; end
    else        begin signed1_i = sgn; op1_1_i = a; op2_1_i = b; end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; req_i = 2'b00;
    signed0_i = 1'b0; signed1_i = 1'b0;
    op1_0_i = '0; op2_0_i = '0; op1_1_i = '0; op2_1_i = '0;
    #2 rst = 1'b0;
    req_i = 2'b10;
    repeat (2) @(negedge clk);
    #1;
    check("rst_start", 64'(div_start_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_hi_lo", {hi_o, lo_o}, 64'd0);
    check("rst_ops", {div_op1_o, div_op2_o}, 64'd0);
    check("rst_signed", 64'(div_signed_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'(2'b10));
    req_i = 2'b00;
    @(negedge clk) rst = 1'b1;

    // Slot 0 DIVU 7/2
    @(negedge clk);
    set_slot(0, 1'b0, 32'd7, 32'd2); req_i = 2'b01; t0 = cyc;
    push(1'b0, 32'd1, 32'd3, t0 + 37, 2'b00);
    @(negedge clk);
    check("start_cycle1", 64'(div_start_o), 64'd1);
    check("ops_latched", {div_op1_o, div_op2_o}, {32'd7, 32'd2});
    check("unsigned_routed", 64'(div_signed_o), 64'd0);
    run_until_clear(100);

    // Slot 1 DIV -7/2
    @(negedge clk);
    set_slot(1, 1'b1, 32'hFFFF_FFF9, 32'd2); req_i = 2'b10; t0 = cyc;
    push(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, t0 + 37, 2'b00);
    @(negedge clk);
    check("signed_routed", 64'(div_signed_o), 64'd1);
    run_until_clear(100);

    // Both slots together: slot 0 first, slot 1 granted on the next IDLE
    @(negedge clk);
    set_slot(0, 1'b0, 32'd100, 32'd10);
    set_slot(1, 1'b0, 32'd9, 32'd4);
    req_i = 2'b11; t0 = cyc;
    push(1'b0, 32'd0, 32'd10, t0 + 37, 2'b10);
    push(1'b1, 32'd1, 32'd2, t0 + 75, 2'b00);
    @(negedge clk);
    check("prio_slot0_op1", 64'(div_op1_o), 64'd100);
    check("loser_stalled", 64'(stall_o), 64'(2'b11));
    run_until_clear(200);

    // Divide by zero, short path
    @(negedge clk);
    set_slot(0, 1'b0, 32'd5, 32'd0); req_i = 2'b01; t0 = cyc;
    push(1'b0, 32'd0, 32'd0, t0 + 5, 2'b00);
    run_until_clear(50);

    // Flush in BUSY cycle 10
    @(negedge clk);
    set_slot(0, 1'b0, 32'd50, 32'd7); req_i = 2'b01;
    repeat (10) @(negedge clk);
    flush_i = 1'b1; req_i = 2'b00;
    #1 check("div_flush_follows", 64'(div_flush_o), 64'd1);
    check("done_masked_flush", 64'(done_o), 64'd0);
    @(negedge clk) flush_i = 1'b0;
    check("start_dropped_flush", 64'(div_start_o), 64'd0);
    repeat (40) @(negedge clk);
    check("idle_after_flush", 64'(div_start_o), 64'd0);
    set_slot(0, 1'b0, 32'd15, 32'd4); req_i = 2'b01; t0 = cyc;
    push(1'b0, 32'd3, 32'd3, t0 + 37, 2'b00);
    run_until_clear(100);

    // Asynchronous reset in BUSY cycle 20
    @(negedge clk);
    set_slot(1, 1'b0, 32'd20, 32'd6); req_i = 2'b10;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_start", 64'(div_start_o), 64'd0);
    check("midrst_hi_lo", {hi_o, lo_o}, 64'd0);
    check("midrst_ops", {div_op1_o, div_op2_o}, 64'd0);
    check("midrst_stall", 64'(stall_o), 64'(2'b10));
    check("midrst_done", 64'(done_o), 64'd0);
    req_i = 2'b00;
    @(negedge clk) rst = 1'b1;
    repeat (40) @(negedge clk);
    set_slot(0, 1'b0, 32'd6, 32'd3); req_i = 2'b01; t0 = cyc;
    push(1'b0, 32'd0, 32'd2, t0 + 37, 2'b00);
    run_until_clear(100);

    repeat (3) @(negedge clk);
    check("hi_lo_held", {hi_o, lo_o}, {32'd0, 32'd2});
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sched.md
# div_sched

Sequencer and two-port arbiter for the shared iterative 32-bit divider in the execute stage. It accepts DIV/DIVU requests from two issue slots, grants one at a time, and drives the divider's start/stop handshake. It captures the 64-bit result as HI/LO, stalls each requester until its result is delivered, and cancels in-flight work on pipeline flush.

## Interface
- No parameters; data width is 32, result width is 64.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset (low = reset asserted).
- `flush_i`  in  1  pipeline flush; kills any queued or in-flight divide.
- `req_i`  in  2  per-slot divide request; bit 0 is the older slot. Held high until the slot's `done_o`.
- `signed0_i`, `signed1_i`  in  1  per-slot signed divide (DIV = 1, DIVU = 0).
- `op1_0_i`, `op2_0_i`, `op1_1_i`, `op2_1_i`  in  32  per-slot dividend and divisor.
- `stall_o`  out  2  per-slot stall: `stall_o[k] = req_i[k] & ~(done_o & done_id_o == k)`. Combinational.
- `done_o`  out  1  one-cycle result-valid pulse.
- `done_id_o`  out  1  slot that owns the result.
- `hi_o`  out  32  remainder; `lo_o`  out 32  quotient. Registered; held until the next capture.
- `div_start_o`  out  1  registered; goes to the divider's `start_i`.
- `div_signed_o`  out  1  registered; goes to the divider's `signed_div_i`.
- `div_op1_o`, `div_op2_o`  out  32  registered operands for the divider.
- `div_flush_o`  out  1  combinational, equals `flush_i`; goes to the divider's `flush`.
- The divider's `annul_i` is tied to 0 at the integration level.
- `div_result_i`  in  64  from the divider: {remainder, quotient}.
- `div_ready_i`  in  1  divider result ready.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Registers: `owner`, operand and sign registers, `hi_o`/`lo_o`, `div_start_o`.
- IDLE:
  - If `flush_i` is high, stay in IDLE. This takes priority over any request.
  - Otherwise, if `req_i != 0`, grant with fixed priority: slot 0 wins over slot 1.
  - On grant: latch the winner's sign and operands into `div_*_o`, set `owner`, set `div_start_o` = 1, and go to BUSY.
- BUSY:
  - `div_start_o` is held at 1.
  - If `flush_i` is high: set `div_start_o` = 0 and go to IDLE. No `done_o` is produced, and the result is discarded.
  - Else, when `div_ready_i` is high: capture `hi_o` = `div_result_i[63:32]` and `lo_o` = `div_result_i[31:0]`, set `done_id_o` = `owner`, set `div_start_o` = 0, and go to DONE.
- DONE:
  - `done_o` = `~flush_i` (the pulse is masked on flush).
  - Unconditionally go to IDLE next cycle.
  - The divider sees `start_i` = 0 in its end state this cycle and returns to free.
- The divider's `flush` (driven by `div_flush_o`) returns it to free on the same edge as this block leaves BUSY. This keeps the two state machines aligned.
- Divide-by-zero needs no special case. The divider returns 0 for both halves via its short path, and `hi_o`/`lo_o` = 0.
- Sign handling is done entirely in the divider. This block only routes the `signed` bit.
- `done_o` is never high outside DONE. `div_start_o` is never high outside BUSY.

## Timing
- Reset values (asynchronous on `rst` low):
  - state = IDLE, `div_start_o` = 0, `div_signed_o` = 0.
  - `div_op1_o` = `div_op2_o` = 0, `hi_o` = `lo_o` = 0.
  - `done_id_o` = 0, `owner` = 0.
  - Resulting outputs: `done_o` = 0, and `stall_o` = `req_i`.
- Reset mid-operation returns to IDLE immediately. The divider must be reset or flushed by the system in the same window.
- Request seen in IDLE at cycle 0 → `div_start_o` is high from cycle 1.
- `done_o` is high the cycle after the first BUSY cycle in which `div_ready_i` = 1.
- Nonzero divisor: `div_ready_i` rises at cycle 36 and `done_o` is at cycle 37.
- Zero divisor: `div_ready_i` rises at cycle 4 and `done_o` is at cycle 5.
- Back-to-back: IDLE is re-entered the cycle after DONE, so the next grant issues 2 cycles after `done_o`.
- The losing requester stays stalled throughout and is granted on the first IDLE cycle.
- Flush in BUSY: IDLE on the next edge. A new request can be granted the cycle after the flush.

## Test plan
- Slot 0 DIVU 7/2 → `done_o` at cycle 37, `done_id_o` = 0, `lo_o` = 3, `hi_o` = 1; `stall_o[0]` drops in the same cycle.
- Slot 1 DIV -7/2 (0xFFFFFFF9/2) → `lo_o` = 0xFFFFFFFD, `hi_o` = 0xFFFFFFFF, `done_id_o` = 1.
- Both slots request together (slot 0 100/10, slot 1 9/4) → slot 0 done first with `lo_o` = 10, `hi_o` = 0. Then slot 1 with `lo_o` = 2, `hi_o` = 1. `stall_o[1]` stays high until its own `done_o`.
- Divisor 0 → `done_o` at cycle 5 with `hi_o` = `lo_o` = 0.
- `flush_i` at BUSY cycle 10 → `div_flush_o` pulses, no `done_o`, state IDLE. A new 15/4 request then completes with `lo_o` = 3, `hi_o` = 3.
- `rst` low at BUSY cycle 20 → all outputs take their reset values asynchronously, with no `done_o`. After release, a 6/3 request completes with `lo_o` = 2.
